// File: rtl/adc_timing_pkg.sv
// Shared types and the scale-to-period table for ADC sample timing.
// Used by the sample timer and by any controller that needs the same period map.
package adc_timing_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_CONT  = 2'd0,
    M_BURST = 2'd1,
    M_TRIG  = 2'd2,
    M_RSVD  = 2'd3
  } mode_t;

  localparam int unsigned DEFAULT_PERIOD = 10000;

  // Table lookup, then clamp up to min_p and saturate to a cnt_w-bit field.
  function automatic logic [63:0] scale_to_period(
    input logic [31:0] scale,
    input logic [63:0] custom,
    input int unsigned cnt_w,
    input int unsigned min_p
  );
    logic [63:0] p;
    logic [63:0] lim;
    case (scale)
      32'd0:   p = custom;
      32'd1:   p = 64'd4;
      32'd2:   p = 64'd6;
      32'd3:   p = 64'd10;
      32'd4:   p = 64'd100;
      32'd5:   p = 64'd200;
      32'd6:   p = 64'd1000;
      32'd7:   p = 64'd2000;
      32'd8:   p = 64'd10000;
      32'd9:   p = 64'd20000;
      32'd10:  p = 64'd100000;
      32'd11:  p = 64'd200000;
      32'd12:  p = 64'd400000;
      32'd13:  p = 64'd1000000;
      32'd14:  p = 64'd2000000;
      32'd15:  p = 64'd4000000;
      32'd16:  p = 64'd10000000;
      default: p = 64'(DEFAULT_PERIOD);
    endcase
    if (p < 64'(min_p)) p = 64'(min_p);
    lim = (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
    if (p > lim) p = lim;
    return p;
  endfunction

endpackage

// File: rtl/sample_period_lut.sv
// Combinational scale/custom to period lookup, reusable by other controllers.
module sample_period_lut
  import adc_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SCALE_W    = 5,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [CNT_W-1:0]   custom_i,
  output logic [CNT_W-1:0]   period_o
);

  assign period_o = CNT_W'(scale_to_period(32'(scale_i), 64'(custom_i),
                                           CNT_W, MIN_PERIOD));

endmodule

// File: rtl/adc_sample_timer.sv
// Periodic ADC sample strobe with continuous, burst and triggered-burst modes.
// Period changes are applied only on tick cycles so no period is ever cut short.
module adc_sample_timer
  import adc_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SCALE_W    = 5,
  parameter int unsigned BURST_W    = 16,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic [CNT_W-1:0]   custom_period,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               trig_in,
  output logic               sample_tick,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   period_active
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               burst_q, burst_d;
  logic               trig_s_q, trig_p_q;

  logic [CNT_W-1:0]   period;
  logic [BURST_W-1:0] blen_eff;
  mode_t              mode_e;
  logic               abort;
  logic               rise;
  logic               tick_w;
  logic               done_w;

  sample_period_lut #(
    .CNT_W      (CNT_W),
    .SCALE_W    (SCALE_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_lut (
    .scale_i  (scale_in),
    .custom_i (custom_period),
    .period_o (period)
  );

  assign mode_e   = mode_t'(mode);
  assign blen_eff = (burst_len == '0) ? BURST_W'(1) : burst_len;
  assign abort    = stop | ~enable;
  assign rise     = trig_s_q & ~trig_p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    tick_w  = 1'b0;
    done_w  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          burst_d = (mode_e == M_BURST) || (mode_e == M_TRIG);
          if (mode_e == M_TRIG) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_RUN;
            per_d   = period;
            cnt_d   = period - CNT_W'(1);
            rem_d   = blen_eff;
          end
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
          per_d   = '0;
        end else if (rise) begin
          state_d = S_RUN;
          per_d   = period;
          cnt_d   = period - CNT_W'(1);
          rem_d   = blen_eff;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          per_d   = '0;
          rem_d   = '0;
        end else if (cnt_q == '0) begin
          tick_w = 1'b1;
          per_d  = period;
          cnt_d  = period - CNT_W'(1);
          if (burst_q) begin
            rem_d = rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) begin
              state_d = S_DONE;
              done_w  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      rem_q    <= '0;
      burst_q  <= 1'b0;
      trig_s_q <= 1'b0;
      trig_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      rem_q    <= rem_d;
      burst_q  <= burst_d;
      trig_s_q <= trig_in;
      trig_p_q <= trig_s_q;
    end
  end

  assign sample_tick   = tick_w;
  assign done          = done_w;
  assign busy          = ((state_q == S_ARMED) || (state_q == S_RUN)) & ~done_w;
  assign period_active = per_q;

endmodule

// File: tb/tb_adc_sample_timer.sv
// Directed-vector bench for adc_sample_timer.
// Cycle c is the interval after the c-th rising edge of a scenario; start is driven in c0.
module tb_adc_sample_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [4:0]  scale_in;
  logic [31:0] custom_period;
  logic [15:0] burst_len;
  logic        trig_in;
  logic        sample_tick;
  logic        busy;
  logic        done;
  logic [31:0] period_active;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_sample_timer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .scale_in      (scale_in),
    .custom_period (custom_period),
    .burst_len     (burst_len),
    .trig_in       (trig_in),
    .sample_tick   (sample_tick),
    .busy          (busy),
    .done          (done),
    .period_active (period_active)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    enable        = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    mode          = 2'd0;
    scale_in      = 5'd1;
    custom_period = 32'd0;
    burst_len     = 16'd0;
    trig_in       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] m, input logic [4:0] s,
                    input logic [31:0] cp, input logic [15:0] bl);
    mode          = m;
    scale_in      = s;
    custom_period = cp;
    burst_len     = bl;
    start         = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tick"}, sample_tick, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " per"}, period_active, 0);
  endtask

  initial begin
    rst = 1'b1;
    #2;
    chk_idle("rst");
    do_reset();

    // Continuous, P=4: ticks at 4,8,12,...
    for (int c = 0; c <= 20; c++) begin
      if (c == 0) go(2'd0, 5'd1, 32'd0, 16'd0);
      if (c == 1) start = 1'b0;
      @(negedge clk);
      chk($sformatf("cont tick c%0d", c), sample_tick, (c >= 4 && c % 4 == 0));
      chk($sformatf("cont busy c%0d", c), busy, (c >= 1));
      chk($sformatf("cont done c%0d", c), done, 0);
      if (c == 1) chk("cont per", period_active, 4);
      step();
    end
    do_reset();

    // Burst of 3, P=10: ticks 10,20,30; done with the last tick.
    for (int c = 0; c <= 33; c++) begin
      if (c == 0) go(2'd1, 5'd3, 32'd0, 16'd3);
      if (c == 1) start = 1'b0;
      @(negedge clk);
      chk($sformatf("burst tick c%0d", c), sample_tick,
          (c == 10 || c == 20 || c == 30));
      chk($sformatf("burst done c%0d", c), done, (c == 30));
      chk($sformatf("burst busy c%0d", c), busy, (c >= 1 && c <= 29));
      step();
    end
    do_reset();

    // Period change mid-period: 4 -> 10 takes effect at the tick on 8.
    for (int c = 0; c <= 30; c++) begin
      if (c == 0) go(2'd0, 5'd1, 32'd0, 16'd0);
      if (c == 1) start = 1'b0;
      if (c == 5) scale_in = 5'd3;
      @(negedge clk);
      chk($sformatf("chg tick c%0d", c), sample_tick,
          (c == 4 || c == 8 || c == 18 || c == 28));
      if (c == 7) chk("chg per old", period_active, 4);
      if (c == 9) chk("chg per new", period_active, 10);
      step();
    end
    do_reset();

    // Triggered burst of 2, P=6, trigger rises at 20: ticks 27,33.
    for (int c = 0; c <= 36; c++) begin
      if (c == 0) go(2'd2, 5'd2, 32'd0, 16'd2);
      if (c == 1) start = 1'b0;
      if (c == 20) trig_in = 1'b1;
      @(negedge clk);
      chk($sformatf("trig tick c%0d", c), sample_tick, (c == 27 || c == 33));
      chk($sformatf("trig done c%0d", c), done, (c == 33));
      chk($sformatf("trig busy c%0d", c), busy, (c >= 1 && c <= 32));
      step();
    end
    do_reset();

    // Custom period 1 clamps to 2.
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) go(2'd0, 5'd0, 32'd1, 16'd0);
      if (c == 1) start = 1'b0;
      @(negedge clk);
      chk($sformatf("cust tick c%0d", c), sample_tick, (c >= 2 && c % 2 == 0));
      if (c == 1) chk("cust per", period_active, 2);
      step();
    end
    do_reset();

    // Out-of-table scale falls back to the default period.
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) go(2'd3, 5'd25, 32'd0, 16'd0);
      if (c == 1) start = 1'b0;
      @(negedge clk);
      chk($sformatf("dflt tick c%0d", c), sample_tick, 0);
      if (c == 1) chk("dflt per", period_active, 10000);
      step();
    end
    do_reset();

    // burst_len 0 behaves as 1.
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) go(2'd1, 5'd1, 32'd0, 16'd0);
      if (c == 1) start = 1'b0;
      @(negedge clk);
      chk($sformatf("bl0 tick c%0d", c), sample_tick, (c == 4));
      chk($sformatf("bl0 done c%0d", c), done, (c == 4));
      step();
    end
    do_reset();

    // Stop on a tick cycle mid-burst.
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) go(2'd1, 5'd1, 32'd0, 16'd5);
      if (c == 1) start = 1'b0;
      if (c == 8) stop = 1'b1;
      if (c == 9) stop = 1'b0;
      @(negedge clk);
      if (c < 8) chk($sformatf("stop tick c%0d", c), sample_tick, (c == 4));
      if (c == 8) begin
        chk("stop tick c8", sample_tick, 0);
        chk("stop done c8", done, 0);
      end
      if (c >= 9) chk_idle($sformatf("stop c%0d", c));
      step();
    end
    do_reset();

    // Asynchronous reset on a tick cycle mid-burst.
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) go(2'd1, 5'd1, 32'd0, 16'd5);
      if (c == 1) start = 1'b0;
      if (c == 8) #2 rst = 1'b1;
      if (c == 9) rst = 1'b0;
      @(negedge clk);
      if (c < 8) chk($sformatf("arst tick c%0d", c), sample_tick, (c == 4));
      if (c >= 8) chk_idle($sformatf("arst c%0d", c));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
